seg_scan_driver: RTL and testbench

Parametrised successor to the fixed 8-digit seven-segment interface used for the coin display. It time-multiplexes NUM_DIGITS hex digits onto a shared active-low segment bus. Beyond plain scanning, it snapshots its inputs per frame (no tearing), applies leading-zero blanking, adds anode dead-time against ghosting, and provides PWM brightness control. It sits beside VGA_Draw on the 25 MHz domain and drives the board's a–g, dp and an pins.

---
 rtl/seg_pkg.sv | 55 +++++
 rtl/seg_hex_decoder.sv | 20 ++
 rtl/seg_scan_driver.sv | 119 +++++++++++
 tb/tb_seg_scan_driver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low glyphs in {a,b,c,d,e,f,g} order
// (bit 6 = a, bit 0 = g) plus the hex-to-segment lookup.
package seg_pkg;

    localparam int SEG_A_BIT = 6;
    localparam int SEG_B_BIT = 5;
    localparam int SEG_C_BIT = 4;
    localparam int SEG_D_BIT = 3;
    localparam int SEG_E_BIT = 2;
    localparam int SEG_F_BIT = 1;
    localparam int SEG_G_BIT = 0;

    localparam logic [6:0] SEG_HEX_0 = 7'b0000001;
    localparam logic [6:0] SEG_HEX_1 = 7'b1001111;
    localparam logic [6:0] SEG_HEX_2 = 7'b0010010;
    localparam logic [6:0] SEG_HEX_3 = 7'b0000110;
    localparam logic [6:0] SEG_HEX_4 = 7'b1001100;
    localparam logic [6:0] SEG_HEX_5 = 7'b0100100;
    localparam logic [6:0] SEG_HEX_6 = 7'b0100000;
    localparam logic [6:0] SEG_HEX_7 = 7'b0001111;
    localparam logic [6:0] SEG_HEX_8 = 7'b0000000;
    localparam logic [6:0] SEG_HEX_9 = 7'b0000100;
    localparam logic [6:0] SEG_HEX_A = 7'b0001000;
    localparam logic [6:0] SEG_HEX_B = 7'b1100000;
    localparam logic [6:0] SEG_HEX_C = 7'b0110001;
    localparam logic [6:0] SEG_HEX_D = 7'b1000010;
    localparam logic [6:0] SEG_HEX_E = 7'b0110000;
    localparam logic [6:0] SEG_HEX_F = 7'b0111000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
        logic [6:0] seg;
        seg = SEG_BLANK;
        case (value)
            4'h0: seg = SEG_HEX_0;
            4'h1: seg = SEG_HEX_1;
            4'h2: seg = SEG_HEX_2;
            4'h3: seg = SEG_HEX_3;
            4'h4: seg = SEG_HEX_4;
            4'h5: seg = SEG_HEX_5;
            4'h6: seg = SEG_HEX_6;
            4'h7: seg = SEG_HEX_7;
            4'h8: seg = SEG_HEX_8;
            4'h9: seg = SEG_HEX_9;
            4'hA: seg = SEG_HEX_A;
            4'hB: seg = SEG_HEX_B;
            4'hC: seg = SEG_HEX_C;
            4'hD: seg = SEG_HEX_D;
            4'hE: seg = SEG_HEX_E;
            default: seg = SEG_HEX_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// Registered hex nibble to active-low segment decode; blank forces all segments off.
module seg_hex_decoder
    import seg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] value,
    input  logic       blank,
    output logic [6:0] segments
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            segments <= SEG_BLANK;
        end else begin
            segments <= blank ? SEG_BLANK : hex_to_seg(value);
        end
    end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with per-frame input snapshot,
// leading-zero blanking, anode dead-time and PWM brightness.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int PRESCALE_BITS = 15,
    parameter int BRIGHT_BITS   = 3,
    parameter int DEAD_CYCLES   = 4
) (
    input  logic                      Master_Clock_In,
    input  logic                      Reset_In,
    input  logic [4*NUM_DIGITS-1:0]   Digits_In,
    input  logic [NUM_DIGITS-1:0]     Dp_In,
    input  logic [NUM_DIGITS-1:0]     Digit_En_In,
    input  logic                      Blank_Lead_In,
    input  logic [BRIGHT_BITS-1:0]    Brightness_In,
    output logic [6:0]                Segments_Out,
    output logic                      Dp_Out,
    output logic [NUM_DIGITS-1:0]     An_Out,
    output logic                      Frame_Tick_Out
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    logic [PRESCALE_BITS-1:0] prescale;
    logic [IDX_W-1:0]         index;
    logic                     slot_end;
    logic                     frame_wrap;

    logic [4*NUM_DIGITS-1:0]  snap_digits;
    logic [NUM_DIGITS-1:0]    snap_dp;
    logic [NUM_DIGITS-1:0]    snap_en;
    logic                     snap_blank_lead;
    logic [BRIGHT_BITS-1:0]   snap_bright;

    logic [NUM_DIGITS-1:0]    lead_zero;
    logic                     blank_run;
    logic [3:0]               cur_digit;
    logic                     cur_en;
    logic                     cur_dp;
    logic [BRIGHT_BITS-1:0]   pwm_phase;
    logic                     an_on;

    assign slot_end   = &prescale;
    assign frame_wrap = slot_end && (index == LAST_IDX);

    // Reset parks the scan on the last slot's final clock so release starts a frame.
    always_ff @(posedge Master_Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            prescale <= '1;
            index    <= LAST_IDX;
        end else begin
            prescale <= prescale + 1'b1;
            if (slot_end) begin
                index <= (index == LAST_IDX) ? '0 : index + 1'b1;
            end
        end
    end

    always_ff @(posedge Master_Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            snap_digits     <= '0;
            snap_dp         <= '0;
            snap_en         <= '0;
            snap_blank_lead <= 1'b0;
            snap_bright     <= '0;
        end else if (frame_wrap) begin
            snap_digits     <= Digits_In;
            snap_dp         <= Dp_In;
            snap_en         <= Digit_En_In;
            snap_blank_lead <= Blank_Lead_In;
            snap_bright     <= Brightness_In;
        end
    end

    // Blanking runs from the leftmost digit down until a shown value or a point appears.
    always_comb begin
        lead_zero = '0;
        blank_run = snap_blank_lead;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            blank_run = blank_run
                      && ((snap_digits[4*i +: 4] == 4'h0) || !snap_en[i])
                      && !snap_dp[i];
            lead_zero[i] = blank_run;
        end
        lead_zero[0] = 1'b0;
    end

    assign cur_digit = snap_digits[{index, 2'b00} +: 4];
    assign cur_en    = snap_en[index];
    assign cur_dp    = snap_dp[index];
    assign pwm_phase = prescale[PRESCALE_BITS-1 -: BRIGHT_BITS];
    assign an_on     = cur_en
                     && (prescale >= PRESCALE_BITS'(DEAD_CYCLES))
                     && (pwm_phase <= snap_bright);

    always_ff @(posedge Master_Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            An_Out         <= '1;
            Dp_Out         <= 1'b1;
            Frame_Tick_Out <= 1'b0;
        end else begin
            An_Out         <= an_on ? ~(NUM_DIGITS'(1) << index) : '1;
            Dp_Out         <= ~(cur_en && cur_dp);
            Frame_Tick_Out <= frame_wrap;
        end
    end

    seg_hex_decoder u_decoder (
        .clk      (Master_Clock_In),
        .rst      (Reset_In),
        .value    (cur_digit),
        .blank    (lead_zero[index] || !cur_en),
        .segments (Segments_Out)
    );

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: directed and random frames checked every clock
// against a frame-position model of the display.
module tb_seg_scan_driver;

    localparam int ND    = 4;
    localparam int PB    = 4;
    localparam int BB    = 2;
    localparam int DC    = 1;
    localparam int SLOT  = 1 << PB;
    localparam int FRAME = SLOT * ND;
    localparam int PHASE_LEN = SLOT >> BB;

    logic              Master_Clock_In;
    logic              Reset_In;
    logic [4*ND-1:0]   Digits_In;
    logic [ND-1:0]     Dp_In;
    logic [ND-1:0]     Digit_En_In;
    logic              Blank_Lead_In;
    logic [BB-1:0]     Brightness_In;
    logic [6:0]        Segments_Out;
    logic              Dp_Out;
    logic [ND-1:0]     An_Out;
    logic              Frame_Tick_Out;

    typedef struct packed {
        logic [4*ND-1:0] digits;
        logic [ND-1:0]   dp;
        logic [ND-1:0]   en;
        logic            blank;
        logic [BB-1:0]   bright;
    } snap_t;

    int check_count = 0;
    int error_count = 0;

    logic [6:0] seg_table [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    seg_scan_driver #(
        .NUM_DIGITS    (ND),
        .PRESCALE_BITS (PB),
        .BRIGHT_BITS   (BB),
        .DEAD_CYCLES   (DC)
    ) dut (
        .Master_Clock_In (Master_Clock_In),
        .Reset_In        (Reset_In),
        .Digits_In       (Digits_In),
        .Dp_In           (Dp_In),
        .Digit_En_In     (Digit_En_In),
        .Blank_Lead_In   (Blank_Lead_In),
        .Brightness_In   (Brightness_In),
        .Segments_Out    (Segments_Out),
        .Dp_Out          (Dp_Out),
        .An_Out          (An_Out),
        .Frame_Tick_Out  (Frame_Tick_Out)
    );

    initial Master_Clock_In = 1'b0;
    always #5 Master_Clock_In = ~Master_Clock_In;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s at %0t: got %h expected %h", tag, $time, actual, expected);
        end
    endtask

    // What the display should show at frame position pos (digit slot, clock within slot).
    function automatic void expect_outputs(input int pos, input snap_t s,
                                           output logic [6:0] seg, output logic dp,
                                           output logic [ND-1:0] an);
        int  idx;
        int  ph;
        logic en;
        logic blanked;
        idx = pos / SLOT;
        ph  = pos % SLOT;
        en  = s.en[idx];
        blanked = 1'b0;
        if (s.blank && idx > 0) begin
            blanked = 1'b1;
            for (int j = idx; j < ND; j++) begin
                if (!(((s.digits[4*j +: 4] == 4'h0) || !s.en[j]) && !s.dp[j]))
                    blanked = 1'b0;
            end
        end
        seg = (!en || blanked) ? 7'h7F : seg_table[s.digits[4*idx +: 4]];
        dp  = !(en && s.dp[idx]);
        an  = '1;
        if (en && ph >= DC && (ph / PHASE_LEN) <= int'(s.bright))
            an[idx] = 1'b0;
    endfunction

    int    edge_count;
    snap_t cur_snap;
    snap_t prev_snap;
    int    pos;
    logic [6:0]    e_seg;
    logic          e_dp;
    logic [ND-1:0] e_an;

    // Edge k after release shows the frame position reached after edge k-1.
    always @(posedge Master_Clock_In) begin
        if (Reset_In) begin
            edge_count = 0;
            cur_snap   = '0;
            #1;
            checkOutput("rst_an", 32'(An_Out), 32'(ND'('1)));
            checkOutput("rst_seg", 32'(Segments_Out), 32'h7F);
            checkOutput("rst_dp", 32'(Dp_Out), 32'h1);
            checkOutput("rst_tick", 32'(Frame_Tick_Out), 32'h0);
        end else begin
            edge_count++;
            prev_snap = cur_snap;
            if ((edge_count - 1) % FRAME == 0) begin
                cur_snap.digits = Digits_In;
                cur_snap.dp     = Dp_In;
                cur_snap.en     = Digit_En_In;
                cur_snap.blank  = Blank_Lead_In;
                cur_snap.bright = Brightness_In;
            end
            pos = (((edge_count - 2) % FRAME) + FRAME) % FRAME;
            expect_outputs(pos, prev_snap, e_seg, e_dp, e_an);
            #1;
            checkOutput("an", 32'(An_Out), 32'(e_an));
            checkOutput("seg", 32'(Segments_Out), 32'(e_seg));
            checkOutput("dp", 32'(Dp_Out), 32'(e_dp));
            checkOutput("tick", 32'(Frame_Tick_Out), 32'((edge_count - 1) % FRAME == 0));
        end
    end

    task automatic applyStimulus(input logic [4*ND-1:0] d, input logic [ND-1:0] dp,
                                 input logic [ND-1:0] en, input logic bl,
                                 input logic [BB-1:0] br, input int cycles);
        @(negedge Master_Clock_In);
        Digits_In     = d;
        Dp_In         = dp;
        Digit_En_In   = en;
        Blank_Lead_In = bl;
        Brightness_In = br;
        repeat (cycles) @(negedge Master_Clock_In);
    endtask

    function automatic logic [4*ND-1:0] rand_digits();
        logic [4*ND-1:0] d;
        for (int i = 0; i < ND; i++)
            d[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
        return d;
    endfunction

    initial begin
        int waited;
        Reset_In      = 1'b1;
        Digits_In     = 16'h1F80;
        Dp_In         = '0;
        Digit_En_In   = '1;
        Blank_Lead_In = 1'b0;
        Brightness_In = 2'd3;
        repeat (3) @(posedge Master_Clock_In);
        @(negedge Master_Clock_In);
        Reset_In = 1'b0;

        repeat (2 * FRAME) @(negedge Master_Clock_In);
        applyStimulus(16'h0070, 4'b0000, 4'b1111, 1'b1, 2'd3, 2 * FRAME);
        applyStimulus(16'h0070, 4'b0100, 4'b1111, 1'b1, 2'd3, 2 * FRAME);
        applyStimulus(16'h1F80, 4'b0000, 4'b1111, 1'b0, 2'd0, 2 * FRAME);
        applyStimulus(16'h1F80, 4'b0000, 4'b1111, 1'b0, 2'd1, 2 * FRAME);
        applyStimulus(16'h1F80, 4'b0000, 4'b1011, 1'b0, 2'd3, 2 * FRAME);
        applyStimulus(16'h0A05, 4'b0001, 4'b1111, 1'b1, 2'd2, 2 * SLOT + 5);
        applyStimulus(16'h3C00, 4'b0000, 4'b1111, 1'b1, 2'd2, 2 * FRAME);

        repeat (20 * FRAME) begin
            @(negedge Master_Clock_In);
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 4))
                    0: Digits_In     = rand_digits();
                    1: Dp_In         = ($urandom_range(0, 1) == 0) ? '0 : ND'($urandom);
                    2: Digit_En_In   = ($urandom_range(0, 1) == 0) ? '1 : ND'($urandom);
                    3: Blank_Lead_In = 1'($urandom);
                    default: Brightness_In = BB'($urandom);
                endcase
            end
        end

        applyStimulus(16'h1234, 4'b0000, 4'b1111, 1'b0, 2'd3, 2 * FRAME + SLOT);
        waited = 0;
        while (An_Out == '1 && waited < FRAME) begin
            @(negedge Master_Clock_In);
            waited++;
        end
        checkOutput("an_active_before_reset", 32'(An_Out != '1), 32'h1);
        @(posedge Master_Clock_In);
        #3 Reset_In = 1'b1;
        #1;
        checkOutput("async_an", 32'(An_Out), 32'(ND'('1)));
        checkOutput("async_seg", 32'(Segments_Out), 32'h7F);
        repeat (2) @(negedge Master_Clock_In);
        Reset_In = 1'b0;
        repeat (FRAME + 8) @(negedge Master_Clock_In);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
